rv32_alu_arbiter: RTL

RV32_ALU_ARBITER -- requirements
Module: rv32_alu_arbiter

---
 rtl/rv32_alu_arbiter_if.sv | 58 +++++
 rtl/rv32_alu_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rv32_alu_arbiter_if.sv
// rtl/rv32_alu_arbiter_if.sv - requester, response and ALU signal bundle for the two-port ALU arbiter
interface rv32_alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_opsel;
  logic [3:0]  req0_bshift;
  logic [31:0] req0_rs1;
  logic [31:0] req0_rs2;
  logic [31:0] req0_pc;
  logic [31:0] req0_code;

  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_opsel;
  logic [3:0]  req1_bshift;
  logic [31:0] req1_rs1;
  logic [31:0] req1_rs2;
  logic [31:0] req1_pc;
  logic [31:0] req1_code;

  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  logic        alu_enable;
  logic [4:0]  alu_opsel;
  logic [3:0]  alu_bshift_ctrl;
  logic [31:0] alu_reg_s1;
  logic [31:0] alu_reg_s2;
  logic [31:0] alu_pc;
  logic [31:0] alu_code_bus;
  logic [31:0] alu_reg_d1;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_opsel, req0_bshift, req0_rs1, req0_rs2, req0_pc, req0_code,
    input  req1_valid, req1_opsel, req1_bshift, req1_rs1, req1_rs2, req1_pc, req1_code,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    input  rsp0_ready, rsp1_ready,
    output alu_enable, alu_opsel, alu_bshift_ctrl, alu_reg_s1, alu_reg_s2, alu_pc, alu_code_bus,
    input  alu_reg_d1
  );

  // Requesters plus ALU side
  modport master (
    output req0_valid, req0_opsel, req0_bshift, req0_rs1, req0_rs2, req0_pc, req0_code,
    output req1_valid, req1_opsel, req1_bshift, req1_rs1, req1_rs2, req1_pc, req1_code,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    output rsp0_ready, rsp1_ready,
    input  alu_enable, alu_opsel, alu_bshift_ctrl, alu_reg_s1, alu_reg_s2, alu_pc, alu_code_bus,
    output alu_reg_d1
  );
endinterface

// File: rtl/rv32_alu_arbiter.sv
// rtl/rv32_alu_arbiter.sv - two-requester ALU arbiter with alternating priority and held responses
module rv32_alu_arbiter #(
  parameter logic RESET_PRIO = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  rv32_alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        gnt_q, gnt_d;
  logic [4:0]  opsel_q, opsel_d;
  logic [3:0]  bshift_q, bshift_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] code_q, code_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;

  logic        gnt_sel;
  logic        accept;
  logic        rsp_hs;
  logic        illegal;

  // Shifter requests bypass the opsel range check; only plain ALU ops can be illegal
  assign illegal = !bshift_q[3] && (opsel_q > 5'd16);

  // Grant selection and requester ready: lone valid wins, a tie goes to the priority holder
  always_comb begin
    gnt_sel = prio_q;
    if (bus.req0_valid && !bus.req1_valid) begin
      gnt_sel = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      gnt_sel = 1'b1;
    end
    bus.req0_ready = rst_n && (state_q == IDLE) && bus.req0_valid && !gnt_sel;
    bus.req1_ready = rst_n && (state_q == IDLE) && bus.req1_valid && gnt_sel;
    accept = bus.req0_ready || bus.req1_ready;
    rsp_hs = (state_q == RESP) && (gnt_q ? bus.rsp1_ready : bus.rsp0_ready);
  end

  // Next state, operand capture, result capture and priority hand-over
  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    gnt_d    = gnt_q;
    opsel_d  = opsel_q;
    bshift_d = bshift_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    pc_d     = pc_q;
    code_d   = code_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = EXEC;
          gnt_d    = gnt_sel;
          opsel_d  = gnt_sel ? bus.req1_opsel  : bus.req0_opsel;
          bshift_d = gnt_sel ? bus.req1_bshift : bus.req0_bshift;
          rs1_d    = gnt_sel ? bus.req1_rs1    : bus.req0_rs1;
          rs2_d    = gnt_sel ? bus.req1_rs2    : bus.req0_rs2;
          pc_d     = gnt_sel ? bus.req1_pc     : bus.req0_pc;
          code_d   = gnt_sel ? bus.req1_code   : bus.req0_code;
        end
      end
      EXEC: begin
        state_d  = RESP;
        result_d = illegal ? 32'd0 : bus.alu_reg_d1;
        err_d    = illegal;
      end
      RESP: begin
        if (rsp_hs) begin
          state_d = IDLE;
          prio_d  = !gnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU drive: operands only leave the block during EXEC
  always_comb begin
    bus.alu_enable      = 1'b0;
    bus.alu_opsel       = 5'd0;
    bus.alu_bshift_ctrl = 4'd0;
    bus.alu_reg_s1      = 32'd0;
    bus.alu_reg_s2      = 32'd0;
    bus.alu_pc          = 32'd0;
    bus.alu_code_bus    = 32'd0;
    if (state_q == EXEC) begin
      bus.alu_reg_s1   = rs1_q;
      bus.alu_reg_s2   = rs2_q;
      bus.alu_pc       = pc_q;
      bus.alu_code_bus = code_q;
      if (bshift_q[3]) begin
        bus.alu_bshift_ctrl = bshift_q;
      end else if (!illegal) begin
        bus.alu_enable = 1'b1;
        bus.alu_opsel  = opsel_q;
      end
    end
  end

  // Response drive: held result and error toward the granted requester only
  always_comb begin
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp_data   = 32'd0;
    bus.rsp_err    = 1'b0;
    if (state_q == RESP) begin
      bus.rsp0_valid = !gnt_q;
      bus.rsp1_valid = gnt_q;
      bus.rsp_data   = result_q;
      bus.rsp_err    = err_q;
    end
  end

  // State and datapath registers; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prio_q   <= RESET_PRIO;
      gnt_q    <= 1'b0;
      opsel_q  <= 5'd0;
      bshift_q <= 4'd0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      pc_q     <= 32'd0;
      code_q   <= 32'd0;
      result_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      gnt_q    <= gnt_d;
      opsel_q  <= opsel_d;
      bshift_q <= bshift_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      pc_q     <= pc_d;
      code_q   <= code_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule
